gray_code_counter: RTL and testbench

- Parametrised, registered Gray-code counter; the sequential successor to the team's 4-bit combinational binary-to-Gray converter.
- Holds a binary count and presents both the binary and Gray encodings every cycle.
- Supports up/down counting, enable, and parallel load in either encoding (Gray loads are converted back to binary).
- Selectable wrap or saturate at the count limits.
- Intended for async-FIFO pointers, position encoders and low-toggle status counters.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/gray_code_counter_g2b.sv | 13 +
 rtl/gray_code_counter.sv | 77 +++++++
 tb/tb_gray_code_counter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for counters and FIFO pointer logic.
package gray_pkg;

   localparam int GW = 64;

   function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] bin);
      return bin ^ (bin >> 1);
   endfunction

   // Prefix XOR from the MSB down; zero-extended upper bits are harmless.
   function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] gray);
      logic [GW-1:0] b;
      b = '0;
      b[$bits(gray)-1] = gray[$bits(gray)-1];
      for (int i = $bits(gray) - 2; i >= 0; i--)
         b[i] = b[i+1] ^ gray[i];
      return b;
   endfunction

   function automatic logic [GW-1:0] cnt_max(input int w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/gray_code_counter_g2b.sv
// Combinational Gray-to-binary decoder, reusable by pointer synchronisers.
module gray_code_counter_g2b
   import gray_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   assign bin = WIDTH'(gray2bin(64'(gray)));

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down Gray counter with load, wrap or saturate at limits.
module gray_code_counter
   import gray_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter bit               WRAP_MODE = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             load,
   input  logic             load_is_gray,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] bin_out,
   output logic [WIDTH-1:0] gray_out,
   output logic             tc,
   output logic             wrap_pulse,
   output logic             sat
);

   localparam logic [WIDTH-1:0] MAX = WIDTH'(cnt_max(WIDTH));
   localparam logic [WIDTH-1:0] RST_GRAY =
      WIDTH'(bin2gray(64'(RESET_VAL)));

   logic [WIDTH-1:0] ld_bin;
   logic [WIDTH-1:0] nxt_bin;
   logic [WIDTH-1:0] nxt_gray;
   logic             nxt_wrap;
   logic             nxt_sat;

   gray_code_counter_g2b #(
      .WIDTH(WIDTH)
   ) u_g2b (
      .gray(load_val),
      .bin (ld_bin)
   );

   assign tc = up_dn ? (bin_out == MAX) : (bin_out == '0);

   always_comb begin
      nxt_bin  = bin_out;
      nxt_wrap = 1'b0;
      nxt_sat  = sat;
      if (load) begin
         nxt_bin = load_is_gray ? ld_bin : load_val;
         nxt_sat = 1'b0;
      end else if (en) begin
         if (tc && !WRAP_MODE) begin
            nxt_sat = 1'b1;
         end else begin
            nxt_bin  = up_dn ? bin_out + WIDTH'(1)
                             : bin_out - WIDTH'(1);
            nxt_wrap = tc;
            nxt_sat  = 1'b0;
         end
      end
      // Gray is registered from next-bin so the output never glitches.
      nxt_gray = WIDTH'(bin2gray(64'(nxt_bin)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bin_out    <= RESET_VAL;
         gray_out   <= RST_GRAY;
         wrap_pulse <= 1'b0;
         sat        <= 1'b0;
      end else begin
         bin_out    <= nxt_bin;
         gray_out   <= nxt_gray;
         wrap_pulse <= nxt_wrap;
         sat        <= nxt_sat;
      end
   end

endmodule

// File: tb/tb_gray_code_counter.sv
// Scoreboard bench: four counters (W4 wrap, W4 sat, W2 wrap, W8 wrap).
module tb_gray_code_counter;

   typedef struct packed {
      logic [7:0] bin;
      logic       wp;
      logic       sat;
   } mdl_t;

   typedef struct packed {
      mdl_t m3;
      mdl_t m2;
      mdl_t m1;
      mdl_t m0;
      logic ud;
      logic cnt;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       up_dn = 1'b1;
   logic       load = 1'b0;
   logic       load_is_gray = 1'b0;
   logic [7:0] lv = '0;

   logic [3:0] b0, g0, b1, g1;
   logic [1:0] b2, g2;
   logic [7:0] b3, g3;
   logic       t0, t1, t2, t3;
   logic       w0, w1, w2, w3;
   logic       s0, s1, s2, s3;

   int   vecs = 0;
   int   errs = 0;
   mdl_t st0, st1, st2, st3;
   exp_t sb[$];

   always #5 clk = ~clk;

   gray_code_counter #(.WIDTH(4), .WRAP_MODE(1'b1)) u_w4 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_is_gray(load_is_gray), .load_val(lv[3:0]),
      .bin_out(b0), .gray_out(g0), .tc(t0), .wrap_pulse(w0), .sat(s0));

   gray_code_counter #(.WIDTH(4), .WRAP_MODE(1'b0)) u_s4 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_is_gray(load_is_gray), .load_val(lv[3:0]),
      .bin_out(b1), .gray_out(g1), .tc(t1), .wrap_pulse(w1), .sat(s1));

   gray_code_counter #(.WIDTH(2), .WRAP_MODE(1'b1)) u_w2 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_is_gray(load_is_gray), .load_val(lv[1:0]),
      .bin_out(b2), .gray_out(g2), .tc(t2), .wrap_pulse(w2), .sat(s2));

   gray_code_counter #(.WIDTH(8), .WRAP_MODE(1'b1)) u_w8 (
      .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
      .load_is_gray(load_is_gray), .load_val(lv),
      .bin_out(b3), .gray_out(g3), .tc(t3), .wrap_pulse(w3), .sat(s3));

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      vecs++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic mdl_t step(input mdl_t s, input int w, input bit wm);
      mdl_t       n;
      logic [7:0] mx;
      logic [7:0] g;
      mx = 8'((9'd1 << w) - 9'd1);
      n = s;
      n.wp = 1'b0;
      if (rst) begin
         n.bin = '0;
         n.sat = 1'b0;
      end else if (load) begin
         g = lv & mx;
         n.bin = '0;
         if (load_is_gray) begin
            for (int i = w - 1; i >= 0; i--)
               n.bin[i] = (i == w - 1) ? g[i] : (n.bin[i+1] ^ g[i]);
         end else begin
            n.bin = g;
         end
         n.sat = 1'b0;
      end else if (en) begin
         if ((up_dn && s.bin == mx) || (!up_dn && s.bin == 8'd0)) begin
            if (wm) begin
               n.bin = up_dn ? 8'd0 : mx;
               n.wp = 1'b1;
               n.sat = 1'b0;
            end else begin
               n.sat = 1'b1;
            end
         end else begin
            n.bin = up_dn ? s.bin + 8'd1 : s.bin - 8'd1;
            n.sat = 1'b0;
         end
      end
      return n;
   endfunction

   task automatic cmp(input string nm, input mdl_t m, input int w,
                      input logic ud, input logic [7:0] b,
                      input logic [7:0] g, input logic t,
                      input logic wp, input logic sa);
      logic [7:0] mx;
      logic       tc_e;
      mx = 8'((9'd1 << w) - 9'd1);
      tc_e = ud ? (m.bin == mx) : (m.bin == 8'd0);
      check({nm, ".bin"}, 32'(b), 32'(m.bin));
      check({nm, ".gray"}, 32'(g), 32'(m.bin ^ (m.bin >> 1)));
      check({nm, ".tc"}, 32'(t), 32'(tc_e));
      check({nm, ".wrap"}, 32'(wp), 32'(m.wp));
      check({nm, ".sat"}, 32'(sa), 32'(m.sat));
   endtask

   task automatic cyc(input logic r, input logic ld, input logic lg,
                      input logic e, input logic ud,
                      input logic [7:0] v);
      exp_t       x;
      exp_t       y;
      logic [3:0] pg;
      rst = r;
      load = ld;
      load_is_gray = lg;
      en = e;
      up_dn = ud;
      lv = v;
      st0 = step(st0, 4, 1'b1);
      st1 = step(st1, 4, 1'b0);
      st2 = step(st2, 2, 1'b1);
      st3 = step(st3, 8, 1'b1);
      x.m0 = st0;
      x.m1 = st1;
      x.m2 = st2;
      x.m3 = st3;
      x.ud = ud;
      x.cnt = !r && !ld && e;
      sb.push_back(x);
      #1;
      pg = g0;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
      end else begin
         y = sb.pop_front();
         cmp("w4", y.m0, 4, y.ud, 8'(b0), 8'(g0), t0, w0, s0);
         cmp("s4", y.m1, 4, y.ud, 8'(b1), 8'(g1), t1, w1, s1);
         cmp("w2", y.m2, 2, y.ud, 8'(b2), 8'(g2), t2, w2, s2);
         cmp("w8", y.m3, 8, y.ud, b3, g3, t3, w3, s3);
         if (y.cnt)
            check("w4.gstep", 32'($countones(pg ^ g0)), 32'd1);
      end
   endtask

   initial begin
      st0 = '0;
      st1 = '0;
      st2 = '0;
      st3 = '0;
      @(negedge clk);
      cyc(1, 0, 0, 0, 1, 8'h00);
      cyc(1, 1, 0, 1, 1, 8'h05);
      repeat (17) cyc(0, 0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 0, 1, 8'h00);
      cyc(0, 1, 0, 0, 0, 8'h01);
      repeat (2) cyc(0, 0, 0, 1, 0, 8'h00);
      cyc(0, 0, 0, 0, 0, 8'h00);
      cyc(0, 1, 1, 1, 1, 8'h0D);
      cyc(0, 0, 0, 0, 1, 8'h00);
      cyc(0, 1, 0, 0, 1, 8'h0E);
      repeat (4) cyc(0, 0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 0, 1, 8'h00);
      cyc(0, 0, 0, 1, 0, 8'h00);
      cyc(0, 1, 0, 0, 1, 8'h05);
      cyc(1, 0, 0, 1, 1, 8'h00);
      cyc(0, 0, 0, 0, 1, 8'h00);
      for (int i = 0; i < 400; i++) begin
         cyc(logic'($urandom_range(0, 39) == 0),
             logic'($urandom_range(0, 9) == 0),
             logic'($urandom_range(0, 1)),
             logic'($urandom_range(0, 3) != 0),
             logic'($urandom_range(0, 7) != 0),
             8'($urandom_range(0, 255)));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
